// File: rtl/ifetch_prefetch.sv
// Instruction fetch/prefetch unit: issues sequential word fetches on a req/gnt + rvalid bus,
// buffers returned words (with PC and error flag) in a FIFO and hands them to decode.
module ifetch_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_err_o,
    input  logic        instr_ready_i
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 2;

    logic          r_active;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_disc_cnt;
    logic [CW-1:0] r_occ;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_pcq_wr;
    logic [AW-1:0] r_pcq_rd;
    logic [31:0]   r_fifo_data [DEPTH];
    logic          r_fifo_err  [DEPTH];
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_pcq       [DEPTH];

    logic [SW-1:0] w_credit_sum;
    logic [SW-1:0] w_disc_next;
    logic          w_req;
    logic          w_hs;
    logic          w_rsp_keep;
    logic          w_rsp_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;

    // Credit: buffered + in-flight + to-be-dropped words never exceed the FIFO depth
    always_comb begin
        w_credit_sum = SW'(r_occ) + SW'(r_out_cnt) + SW'(r_disc_cnt);
        w_req        = r_active && !redirect_i && (w_credit_sum < SW'(DEPTH));
        w_hs         = w_req && mem_gnt_i;
        w_rsp_keep   = mem_rvalid_i && (r_disc_cnt == '0);
        w_rsp_drop   = mem_rvalid_i && (r_disc_cnt != '0);
        w_push       = w_rsp_keep && !redirect_i;
        w_nonempty   = (r_occ != '0);
        w_pop        = w_nonempty && instr_ready_i && !redirect_i;
        w_disc_next  = SW'(r_disc_cnt) + SW'(r_out_cnt) + SW'(w_hs) - SW'(mem_rvalid_i);
    end

    assign mem_req_o     = w_req;
    assign mem_addr_o    = r_fetch_pc;
    assign instr_valid_o = w_nonempty;
    assign instr_o       = w_nonempty ? r_fifo_data[r_rd_ptr] : 32'h0;
    assign instr_pc_o    = w_nonempty ? r_fifo_pc[r_rd_ptr]   : 32'h0;
    assign instr_err_o   = w_nonempty ? r_fifo_err[r_rd_ptr]  : 1'b0;

    // Control state: fetch PC, counters, FIFO and PC-queue pointers; redirect flushes everything
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_active   <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_out_cnt  <= '0;
            r_disc_cnt <= '0;
            r_occ      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pcq_wr   <= '0;
            r_pcq_rd   <= '0;
        end else begin
            r_active <= 1'b1;
            if (redirect_i) begin
                r_fetch_pc <= redirect_pc_i & ~32'h3;
                r_disc_cnt <= CW'(w_disc_next);
                r_out_cnt  <= '0;
                r_occ      <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_pcq_wr   <= '0;
                r_pcq_rd   <= '0;
            end else begin
                if (w_hs) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_pcq_wr   <= r_pcq_wr + AW'(1);
                end
                if (w_rsp_keep) begin
                    r_pcq_rd <= r_pcq_rd + AW'(1);
                end
                if (w_rsp_drop) begin
                    r_disc_cnt <= r_disc_cnt - CW'(1);
                end
                r_out_cnt <= r_out_cnt + CW'(w_hs) - CW'(w_rsp_keep);
                r_occ     <= r_occ + CW'(w_push) - CW'(w_pop);
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end
    end

    // Storage: returned words tagged with the PC of their request; contents need no reset
    always_ff @(posedge clk_i) begin
        if (w_hs) begin
            r_pcq[r_pcq_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_rdata_i;
            r_fifo_err[r_wr_ptr]  <= mem_err_i;
            r_fifo_pc[r_wr_ptr]   <= r_pcq[r_pcq_rd];
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Scoreboard bench for ifetch_prefetch: a bus model with programmable latency and grant budget,
// directed scenarios pushing expected words, and a monitor that checks every consumed word.
module tb_ifetch_prefetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_err;
    logic        instr_ready;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          hs_log[$];
    int          pop_log[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          budget = 0;
    int          lat = 1;
    int          grant_cnt = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .mem_err_i     (mem_err),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_err_o   (instr_err),
        .instr_ready_i (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic e);
        exp_t x;
        x.pc   = pc;
        x.word = mem_word(pc);
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
        check(name, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(mem_req),     32'h0);
        check({tag, "_addr"},  mem_addr,         32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_instr"}, instr,            32'h0);
        check({tag, "_pc"},    instr_pc,         32'h0);
        check({tag, "_err"},   32'(instr_err),   32'h0);
    endtask

    // Bus response side: returns in order after the programmed latency, grant follows the budget
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        mem_err    = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                pend_q.delete();
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
                mem_err    = 1'b0;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(pend_q[0].addr);
                mem_err    = (pend_q[0].addr == err_addr);
                void'(pend_q.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_err    = 1'b0;
            end
            #1;
            mem_gnt = (budget > 0);
        end
    end

    // Bus request side: record each handshake mid-cycle
    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req && mem_gnt) begin
                p.addr = mem_addr;
                p.due  = cyc + lat;
                pend_q.push_back(p);
                budget--;
                grant_cnt++;
                hs_log.push_back(cyc);
            end
        end
    end

    // Monitor: every consumed word is compared against the head of the expectation queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && instr_ready && !redirect) begin
                pop_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got pc 0x%08h want none", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc",   instr_pc,        e.pc);
                    check("out_word", instr,           e.word);
                    check("out_err",  32'(instr_err),  32'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int gc0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;

        // Reset values, then release and first request
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("rst");
        tick();
        rst_n  = 1'b1;
        budget = 100;
        tick();
        @(negedge clk);
        check("rel_req",  32'(mem_req), 32'h1);
        check("rel_addr", mem_addr,     32'h0);

        // Core stalled: credit allows exactly DEPTH grants
        push_exp(32'h0, 1'b0);
        push_exp(32'h4, 1'b0);
        push_exp(32'h8, 1'b0);
        push_exp(32'hC, 1'b0);
        repeat (12) tick();
        @(negedge clk);
        check("full_grants", 32'(grant_cnt), 32'd4);
        check("full_req",    32'(mem_req),   32'h0);
        check("full_addr",   mem_addr,       32'h10);
        tick();
        budget      = 0;
        instr_ready = 1'b1;
        wait_drain("full_drain", 20);
        tick();
        @(negedge clk);
        check("resume_req",  32'(mem_req), 32'h1);
        check("resume_addr", mem_addr,     32'h10);

        // Zero-wait stream: 2-cycle first latency, one word per cycle
        tick();
        hs_log.delete();
        pop_log.delete();
        for (int i = 0; i < 8; i++) push_exp(32'h10 + 32'(4 * i), 1'b0);
        budget = 8;
        wait_drain("stream_drain", 30);
        check("stream_pops", 32'(pop_log.size()), 32'd8);
        if (pop_log.size() >= 8 && hs_log.size() >= 1) begin
            check("stream_lat",  32'(pop_log[0] - hs_log[0]), 32'd2);
            check("stream_rate", 32'(pop_log[7] - pop_log[0]), 32'd7);
        end

        // Bus error on 0x8 only tags that word; misaligned redirect target forced to 0
        tick();
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0003;
        tick();
        redirect = 1'b0;
        err_addr = 32'h8;
        push_exp(32'h0, 1'b0);
        push_exp(32'h4, 1'b0);
        push_exp(32'h8, 1'b1);
        push_exp(32'hC, 1'b0);
        budget      = 4;
        instr_ready = 1'b1;
        wait_drain("err_drain", 30);
        err_addr = 32'hFFFF_FFFF;

        // Redirect with two outstanding fetches: both responses dropped
        tick();
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h8;
        tick();
        redirect = 1'b0;
        lat      = 4;
        gc0      = grant_cnt;
        budget   = 2;
        for (int i = 0; i < 10 && grant_cnt < gc0 + 2; i++) tick();
        check("inflight_grants", 32'(grant_cnt), 32'(gc0 + 2));
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        lat         = 1;
        budget      = 2;
        exp_q.delete();
        push_exp(32'h100, 1'b0);
        push_exp(32'h104, 1'b0);
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        wait_drain("flush_drain", 30);

        // Grant stall keeps request stable; redirect during the stall discards nothing
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_req",  32'(mem_req), 32'h1);
            check("stall_addr", mem_addr,     32'h108);
            tick();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        check("redir_req", 32'(mem_req), 32'h0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("redir_new_req",  32'(mem_req), 32'h1);
        check("redir_new_addr", mem_addr,     32'h40);
        tick();
        push_exp(32'h40, 1'b0);
        budget = 1;
        wait_drain("redir_drain", 20);

        // Reset in the middle of outstanding traffic
        tick();
        instr_ready = 1'b0;
        budget      = 2;
        lat         = 4;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        budget = 0;
        lat    = 1;
        repeat (2) tick();
        rst_n  = 1'b1;
        budget = 1;
        tick();
        @(negedge clk);
        check("mid_rel_req",  32'(mem_req), 32'h1);
        check("mid_rel_addr", mem_addr,     32'h0);
        push_exp(32'h0, 1'b0);
        instr_ready = 1'b1;
        wait_drain("mid_drain", 20);

        repeat (6) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
